// File: rtl/seg_scan_ctrl.sv
// Scan controller for a time-multiplexed common-anode 7-seg display with a ghosting guard.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic                    dp_n,
    output logic                    blank,
    output logic                    frame_done
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]      IDX_LAST      = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK_END = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_SLOT_END  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF       = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIG_W-1:0]      r_sh_dig;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic [DIG_W-1:0]      r_disp_dig;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [3:0]            r_nibble;
    logic [NUM_DIGITS-1:0] r_dig_sel_n;
    logic                  r_dp_n;
    logic                  r_blank;
    logic                  r_frame_done;

    logic [IDX_W-1:0]      w_idx_inc;
    logic [NUM_DIGITS-1:0] w_sel_cur;
    logic                  w_dp_cur;
    logic [3:0]            w_nib_next;
    logic                  w_hide;

    function automatic logic [3:0] dig_of(input logic [DIG_W-1:0] v, input logic [IDX_W-1:0] k);
        dig_of = 4'h0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (k == IDX_W'(i)) dig_of = v[4*i +: 4];
        end
    endfunction

    function automatic logic dp_of(input logic [NUM_DIGITS-1:0] v, input logic [IDX_W-1:0] k);
        dp_of = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (k == IDX_W'(i)) dp_of = v[i];
        end
    endfunction

    assign w_idx_inc  = r_idx + IDX_W'(1);
    assign w_sel_cur  = ~(NUM_DIGITS'(1) << r_idx);
    assign w_dp_cur   = dp_of(r_disp_dp, r_idx);
    assign w_nib_next = dig_of(r_disp_dig, w_idx_inc);

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed when it and every more significant digit are zero.
    logic w_upper_zero;
    always_comb begin
        w_upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) >= r_idx && r_disp_dig[4*i +: 4] != 4'h0) w_upper_zero = 1'b0;
        end
    end
    assign w_hide = (r_idx != '0) && w_upper_zero;
`else
    assign w_hide = 1'b0;
`endif

    // Scan FSM; outputs are set on the transition edge so each state's pins are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_sh_dig     <= '0;
            r_sh_dp      <= '0;
            r_disp_dig   <= '0;
            r_disp_dp    <= '0;
            r_nibble     <= 4'h0;
            r_dig_sel_n  <= SEL_OFF;
            r_dp_n       <= 1'b1;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (load) begin
                r_sh_dig <= digits_in;
                r_sh_dp  <= dp_in;
            end

            if (r_state != IDLE && !en) begin
                r_state     <= IDLE;
                r_idx       <= '0;
                r_cnt       <= '0;
                r_nibble    <= 4'h0;
                r_dig_sel_n <= SEL_OFF;
                r_dp_n      <= 1'b1;
                r_blank     <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (en) begin
                            r_state    <= BLANK;
                            r_idx      <= '0;
                            r_cnt      <= '0;
                            r_disp_dig <= r_sh_dig;
                            r_disp_dp  <= r_sh_dp;
                            r_nibble   <= r_sh_dig[3:0];
                        end
                    end
                    BLANK: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_BLANK_END) begin
                            r_state <= SHOW;
                            if (!w_hide) begin
                                r_dig_sel_n <= w_sel_cur;
                                r_blank     <= 1'b0;
                                r_dp_n      <= ~w_dp_cur;
                            end
                        end
                    end
                    SHOW: begin
                        if (r_cnt == CNT_SLOT_END) begin
                            r_state     <= BLANK;
                            r_cnt       <= '0;
                            r_dig_sel_n <= SEL_OFF;
                            r_dp_n      <= 1'b1;
                            r_blank     <= 1'b1;
                            // Frame wrap: snapshot taken here so a frame never tears.
                            if (r_idx == IDX_LAST) begin
                                r_idx        <= '0;
                                r_disp_dig   <= r_sh_dig;
                                r_disp_dp    <= r_sh_dp;
                                r_nibble     <= r_sh_dig[3:0];
                                r_frame_done <= 1'b1;
                            end else begin
                                r_idx    <= w_idx_inc;
                                r_nibble <= w_nib_next;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_nibble    <= 4'h0;
                        r_dig_sel_n <= SEL_OFF;
                        r_dp_n      <= 1'b1;
                        r_blank     <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign nibble_out = r_nibble;
    assign dig_sel_n  = r_dig_sel_n;
    assign dp_n       = r_dp_n;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues expected lit segments, a monitor checks them.
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  nibble_out;
    logic [3:0]  dig_sel_n;
    logic        dp_n;
    logic        blank;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .nibble_out(nibble_out),
        .dig_sel_n (dig_sel_n),
        .dp_n      (dp_n),
        .blank     (blank),
        .frame_done(frame_done)
    );

    // One expected lit segment; gap=0 means the preceding dark run length is not checked.
    typedef struct {
        logic [3:0] sel;
        logic [3:0] nib;
        logic       dpn;
        int         len;
        int         gap;
        int         fd;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] sel, input logic [3:0] nib, input logic dpn,
                        input int len, input int gap, input int fd);
        exp_t e;
        e.sel = sel; e.nib = nib; e.dpn = dpn; e.len = len; e.gap = gap; e.fd = fd;
        q.push_back(e);
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor state for the segment currently lit
    logic       in_lit = 1'b0;
    logic [3:0] s_sel, s_nib;
    logic [3:0] prev_nib = 4'h0;
    logic       s_dpn, s_blank, s_stable, s_pre_ok;
    int         s_len, s_gap, s_fd;
    int         gap_cnt = 0;
    int         fd_cnt  = 0;

    task automatic close_seg();
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_segment: got sel=%b nib=%h required no segment", s_sel, s_nib);
            return;
        end
        e = q.pop_front();
        chk("seg_sel", int'(s_sel), int'(e.sel));
        chk("seg_nibble", int'(s_nib), int'(e.nib));
        chk("seg_dp_n", int'(s_dpn), int'(e.dpn));
        chk("seg_blank", int'(s_blank), 0);
        chk("seg_len", s_len, e.len);
        if (e.gap != 0) chk("seg_gap", s_gap, e.gap);
        chk("seg_frame_done", s_fd, e.fd);
        chk("seg_stable", int'(s_stable), 1);
        chk("seg_nibble_preset", int'(s_pre_ok), 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_lit  = 1'b0;
            gap_cnt = 0;
            fd_cnt  = 0;
        end else begin
            chk("sel_onehot", int'($countones(~dig_sel_n) <= 1), 1);
            if (dig_sel_n == 4'hF) begin
                chk("dark_blank_dp", int'({blank, dp_n}), 3);
                if (in_lit) begin
                    close_seg();
                    in_lit  = 1'b0;
                    gap_cnt = 0;
                    fd_cnt  = 0;
                end
                gap_cnt++;
                if (frame_done) fd_cnt++;
            end else if (!in_lit) begin
                in_lit   = 1'b1;
                s_sel    = dig_sel_n;
                s_nib    = nibble_out;
                s_dpn    = dp_n;
                s_blank  = blank;
                s_len    = 1;
                s_gap    = gap_cnt;
                s_fd     = fd_cnt;
                s_stable = !frame_done;
                s_pre_ok = (nibble_out == prev_nib);
            end else begin
                s_len++;
                if (dig_sel_n != s_sel || nibble_out != s_nib || dp_n != s_dpn ||
                    blank != s_blank || frame_done) s_stable = 1'b0;
            end
        end
        prev_nib = nibble_out;
    end

    initial begin : stim
        int cyc;
        int n;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
        adv(3);
        chk("rst_nibble", int'(nibble_out), 0);
        chk("rst_dig_sel_n", int'(dig_sel_n), 15);
        chk("rst_dp_n", int'(dp_n), 1);
        chk("rst_blank", int'(blank), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a lit slot
        load = 1'b1; digits_in = 16'h1A2F; en = 1'b1;
        adv(1);
        load = 1'b0;
        n = 0;
        while (dig_sel_n == 4'hF && n < 50) begin
            adv(1);
            n++;
        end
        chk("first_lit_timeout", int'(n < 50), 1);
        adv(2);
        #3 rst_n = 1'b0;
        #1;
        chk("midshow_rst_dig_sel_n", int'(dig_sel_n), 15);
        chk("midshow_rst_blank", int'(blank), 1);
        chk("midshow_rst_dp_n", int'(dp_n), 1);
        chk("midshow_rst_nibble", int'(nibble_out), 0);
        en = 1'b0;
        adv(2);
        rst_n = 1'b1;

        // Load 1A2F while idle, then enable: two frames of F,2,A,1
        load = 1'b1; digits_in = 16'h1A2F; dp_in = 4'b0000;
        adv(1);
        load = 1'b0;
        push(4'b1110, 4'hF, 1'b1, 6, 0, 0);
        push(4'b1101, 4'h2, 1'b1, 6, 2, 0);
        push(4'b1011, 4'hA, 1'b1, 6, 2, 0);
        push(4'b0111, 4'h1, 1'b1, 6, 2, 0);
        push(4'b1110, 4'hF, 1'b1, 6, 2, 1);
        push(4'b1101, 4'h2, 1'b1, 6, 2, 0);
        push(4'b1011, 4'hA, 1'b1, 6, 2, 0);
        push(4'b0111, 4'h1, 1'b1, 6, 2, 0);
        en = 1'b1;
        adv(1);
        cyc = 0;

        // Mid-frame load (cycle 10 of frame 1): appears from frame 2, dp on digit 2
        adv(41 - cyc); cyc = 41;
        load = 1'b1; digits_in = 16'h5555; dp_in = 4'b0100;
        push(4'b1110, 4'h5, 1'b1, 6, 2, 1);
        push(4'b1101, 4'h5, 1'b1, 6, 2, 0);
        push(4'b1011, 4'h5, 1'b0, 6, 2, 0);
        push(4'b0111, 4'h5, 1'b1, 6, 2, 0);
        adv(1); cyc = 42;
        load = 1'b0;

        // Load on the wrap edge: frame 3 keeps 5555, frame 4 shows 9876
        adv(95 - cyc); cyc = 95;
        load = 1'b1; digits_in = 16'h9876; dp_in = 4'b0000;
        push(4'b1110, 4'h5, 1'b1, 6, 2, 1);
        push(4'b1101, 4'h5, 1'b1, 6, 2, 0);
        push(4'b1011, 4'h5, 1'b0, 6, 2, 0);
        push(4'b0111, 4'h5, 1'b1, 6, 2, 0);
        push(4'b1110, 4'h6, 1'b1, 6, 2, 1);
        push(4'b1101, 4'h7, 1'b1, 6, 2, 0);
        push(4'b1011, 4'h8, 1'b1, 3, 2, 0);
        adv(1); cyc = 96;
        load = 1'b0;

        // Disable while digit 2 of frame 4 is lit (sampled at edge 149)
        adv(148 - cyc); cyc = 148;
        en = 1'b0;
        adv(1);
        adv(40);

        // Re-enable with fresh snapshot 0040; then 0000 from frame 2
        load = 1'b1; digits_in = 16'h0040; dp_in = 4'b0000;
        adv(1);
        load = 1'b0;
        push(4'b1110, 4'h0, 1'b1, 6, 0, 0);
        push(4'b1101, 4'h4, 1'b1, 6, 2, 0);
`ifdef LEADING_ZERO_BLANK_EN
        push(4'b1110, 4'h0, 1'b1, 6, 18, 1);
        push(4'b1101, 4'h4, 1'b1, 6, 2, 0);
`else
        push(4'b1011, 4'h0, 1'b1, 6, 2, 0);
        push(4'b0111, 4'h0, 1'b1, 6, 2, 0);
        push(4'b1110, 4'h0, 1'b1, 6, 2, 1);
        push(4'b1101, 4'h4, 1'b1, 6, 2, 0);
        push(4'b1011, 4'h0, 1'b1, 6, 2, 0);
        push(4'b0111, 4'h0, 1'b1, 6, 2, 0);
`endif
        en = 1'b1;
        adv(1);
        cyc = 0;

        adv(41 - cyc); cyc = 41;
        load = 1'b1; digits_in = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
        push(4'b1110, 4'h0, 1'b1, 6, 18, 1);
`else
        push(4'b1110, 4'h0, 1'b1, 6, 2, 1);
        push(4'b1101, 4'h0, 1'b1, 6, 2, 0);
        push(4'b1011, 4'h0, 1'b1, 6, 2, 0);
        push(4'b0111, 4'h0, 1'b1, 6, 2, 0);
`endif
        adv(1); cyc = 42;
        load = 1'b0;

        // Stop during the blanking of frame 3 digit 0, before it lights
        adv(96 - cyc); cyc = 96;
        en = 1'b0;
        adv(1);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            adv(1);
            n++;
        end
        adv(4);
        chk("queue_drained", q.size(), 0);
        chk("idle_dark_sel", int'(dig_sel_n), 15);
        chk("idle_frame_done", int'(frame_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
